alu_seq: RTL and testbench

Parametrised, registered successor to the 8-bit combinational ALU. It widens the datapath to `WIDTH` bits and extends the operation set to logic ops, single-bit shifts and an iterative shift-and-add multiply. It adds a start/busy/done handshake and registered Z/C/N/V flags. It sits between the register file and the accumulator write-back in the datapath; the control unit issues one operation at a time and waits for `done_o`.

---
 rtl/alu_seq.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with a start/busy/done handshake and Z/C/N/V flags.
// Single-cycle ops complete at the accept edge; MUL iterates shift-and-add for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] r_o,
  output logic             fz_o,
  output logic             fc_o,
  output logic             fn_o,
  output logic             fv_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   r_q, r_d;
  logic               fz_q, fz_d;
  logic               fc_q, fc_d;
  logic               fn_q, fn_d;
  logic               fv_q, fv_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;

  logic               accept;
  logic               last_iter;
  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH+1:0]   single_res;

  // Returns {carry, overflow, result} for every non-multiply opcode.
  function automatic logic [WIDTH+1:0] alu_single(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic signed [WIDTH-1:0] xs;
    logic signed [WIDTH-1:0] ys;
    logic [WIDTH:0]          wide;
    logic [WIDTH-1:0]        r;
    logic                    c;
    logic                    v;
    xs   = signed'(x);
    ys   = signed'(y);
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, x} + {1'b0, y};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (xs[WIDTH-1] == ys[WIDTH-1]) && (r[WIDTH-1] != xs[WIDTH-1]);
      end
      OP_SUB: begin
        wide = {1'b0, x} - {1'b0, y};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (xs[WIDTH-1] != ys[WIDTH-1]) && (r[WIDTH-1] != xs[WIDTH-1]);
      end
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHL: begin
        r = {x[WIDTH-2:0], 1'b0};
        c = x[WIDTH-1];
      end
      OP_SHR: begin
        r = {1'b0, x[WIDTH-1:1]};
        c = x[0];
      end
      default: ;
    endcase
    return {c, v, r};
  endfunction

  assign accept     = start_i && (state_q == S_IDLE);
  assign last_iter  = (state_q == S_MUL) && (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign single_res = alu_single(op_i, x_i, y_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && (op_i == OP_MUL)) state_d = S_MUL;
      S_MUL:  if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    r_d      = r_q;
    fz_d     = fz_q;
    fc_d     = fc_q;
    fn_d     = fn_q;
    fv_d     = fv_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op_i == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, x_i};
            mplier_d = y_i;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            r_d    = single_res[WIDTH-1:0];
            fc_d   = single_res[WIDTH+1];
            fv_d   = single_res[WIDTH];
            fz_d   = (single_res[WIDTH-1:0] == '0);
            fn_d   = single_res[WIDTH-1];
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_iter) begin
          r_d    = acc_sum[WIDTH-1:0];
          fc_d   = |acc_sum[2*WIDTH-1:WIDTH];
          fv_d   = 1'b0;
          fz_d   = (acc_sum[WIDTH-1:0] == '0);
          fn_d   = acc_sum[WIDTH-1];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Result, flags and handshake registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_q    <= '0;
      fz_q   <= 1'b0;
      fc_q   <= 1'b0;
      fn_q   <= 1'b0;
      fv_q   <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      r_q    <= r_d;
      fz_q   <= fz_d;
      fc_q   <= fc_d;
      fn_q   <= fn_d;
      fv_q   <= fv_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  // Multiply operands carry no reset; they are reloaded on every MUL accept.
  always_ff @(posedge clk_i) begin
    mcand_q  <= mcand_d;
    acc_q    <= acc_d;
    mplier_q <= mplier_d;
  end

  assign r_o    = r_q;
  assign fz_o   = fz_q;
  assign fc_o   = fc_q;
  assign fn_o   = fn_q;
  assign fv_o   = fv_q;
  assign done_o = done_q;
  assign busy_o = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: flags, MUL timing, busy rejection,
// mid-MUL reset and back-to-back issue.
module tb_alu_seq;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, MUL = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op_s = 3'd0;
  logic [7:0] x_s = 8'd0;
  logic [7:0] y_s = 8'd0;
  logic [7:0] r;
  logic       fz, fc, fn, fv, busy, done;

  int errors = 0;
  int checks = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op_s),
    .x_i(x_s), .y_i(y_s), .r_o(r), .fz_o(fz), .fc_o(fc), .fn_o(fn),
    .fv_o(fv), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Presents one request for a single edge; returns on the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    start = 1'b1; op_s = op; x_s = x; y_s = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles until done (bounded), accumulating cycles where busy was high.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    while (done !== 1'b1 && lat < 40) begin
      busy_n += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({r, fz, fc, fn, fv, busy, done} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got=%h want=0", {r, fz, fc, fn, fv, busy, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add;
    issue(ADD, 8'hFF, 8'h01);
    checks++;
    if (r !== 8'h00 || {fz, fc, fn, fv} !== 4'b1100 || done !== 1'b1) begin
      errors++; $display("FAIL add_ff_01 r=%h zcnv=%b done=%b want r=00 zcnv=1100 done=1", r, {fz, fc, fn, fv}, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || r !== 8'h00) begin
      errors++; $display("FAIL add_done_drop done=%b r=%h want done=0 r=00", done, r);
    end
    issue(ADD, 8'h7F, 8'h01);
    checks++;
    if (r !== 8'h80 || {fz, fc, fn, fv} !== 4'b0011 || done !== 1'b1) begin
      errors++; $display("FAIL add_7f_01 r=%h zcnv=%b want r=80 zcnv=0011", r, {fz, fc, fn, fv});
    end
  endtask

  task automatic test_sub;
    issue(SUB, 8'h00, 8'h01);
    checks++;
    if (r !== 8'hFF || {fz, fc, fn, fv} !== 4'b0110) begin
      errors++; $display("FAIL sub_00_01 r=%h zcnv=%b want r=ff zcnv=0110", r, {fz, fc, fn, fv});
    end
    issue(SUB, 8'h80, 8'h01);
    checks++;
    if (r !== 8'h7F || {fz, fc, fn, fv} !== 4'b0001) begin
      errors++; $display("FAIL sub_80_01 r=%h zcnv=%b want r=7f zcnv=0001", r, {fz, fc, fn, fv});
    end
    issue(SUB, 8'h05, 8'h05);
    checks++;
    if (r !== 8'h00 || {fz, fc, fn, fv} !== 4'b1000) begin
      errors++; $display("FAIL sub_05_05 r=%h zcnv=%b want r=00 zcnv=1000", r, {fz, fc, fn, fv});
    end
  endtask

  task automatic test_logic_shift;
    issue(AND_, 8'hF0, 8'h3C);
    checks++;
    if (r !== 8'h30 || {fz, fc, fn, fv} !== 4'b0000) begin
      errors++; $display("FAIL and_f0_3c r=%h zcnv=%b want r=30 zcnv=0000", r, {fz, fc, fn, fv});
    end
    issue(OR_, 8'h0F, 8'hF0);
    checks++;
    if (r !== 8'hFF || {fz, fc, fn, fv} !== 4'b0010) begin
      errors++; $display("FAIL or_0f_f0 r=%h zcnv=%b want r=ff zcnv=0010", r, {fz, fc, fn, fv});
    end
    issue(XOR_, 8'hFF, 8'hFF);
    checks++;
    if (r !== 8'h00 || {fz, fc, fn, fv} !== 4'b1000) begin
      errors++; $display("FAIL xor_ff_ff r=%h zcnv=%b want r=00 zcnv=1000", r, {fz, fc, fn, fv});
    end
    issue(SHL, 8'h81, 8'hA5);
    checks++;
    if (r !== 8'h02 || {fz, fc, fn, fv} !== 4'b0100) begin
      errors++; $display("FAIL shl_81 r=%h zcnv=%b want r=02 zcnv=0100", r, {fz, fc, fn, fv});
    end
    issue(SHR, 8'h01, 8'h5A);
    checks++;
    if (r !== 8'h00 || {fz, fc, fn, fv} !== 4'b1100) begin
      errors++; $display("FAIL shr_01 r=%h zcnv=%b want r=00 zcnv=1100", r, {fz, fc, fn, fv});
    end
  endtask

  task automatic test_mul;
    int lat, busy_n;
    @(negedge clk);
    issue(MUL, 8'h0F, 8'h11);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 8 || busy_n !== 8) begin
      errors++; $display("FAIL mul_timing latency=%0d busy_cycles=%0d want 8 and 8", lat, busy_n);
    end
    checks++;
    if (r !== 8'hFF || {fz, fc, fn, fv} !== 4'b0010 || busy !== 1'b0) begin
      errors++; $display("FAIL mul_0f_11 r=%h zcnv=%b busy=%b want r=ff zcnv=0010 busy=0", r, {fz, fc, fn, fv}, busy);
    end
    @(negedge clk);
    issue(MUL, 8'h10, 8'h10);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 8 || r !== 8'h00 || {fz, fc, fn, fv} !== 4'b1100) begin
      errors++; $display("FAIL mul_10_10 lat=%0d r=%h zcnv=%b want lat=8 r=00 zcnv=1100", lat, r, {fz, fc, fn, fv});
    end
  endtask

  task automatic test_start_while_busy;
    int lat, busy_n;
    @(negedge clk);
    issue(MUL, 8'h0F, 8'h11);
    @(negedge clk);
    start = 1'b1; op_s = ADD; x_s = 8'h01; y_s = 8'h01;
    @(negedge clk);
    start = 1'b0; x_s = 8'h00; y_s = 8'h00;
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 6 || r !== 8'hFF || {fz, fc, fn, fv} !== 4'b0010) begin
      errors++; $display("FAIL busy_ignore lat=%0d r=%h zcnv=%b want lat=6 r=ff zcnv=0010", lat, r, {fz, fc, fn, fv});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || r !== 8'hFF || busy !== 1'b0) begin
      errors++; $display("FAIL busy_not_queued done=%b r=%h busy=%b want done=0 r=ff busy=0", done, r, busy);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic seen_done;
    issue(MUL, 8'h0F, 8'h11);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({r, fz, fc, fn, fv, busy, done} !== 14'd0) begin
      errors++; $display("FAIL midmul_reset got=%h want=0", {r, fz, fc, fn, fv, busy, done});
    end
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen_done |= done;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++; $display("FAIL midmul_no_done seen_done=%b want 0", seen_done);
    end
    issue(ADD, 8'h01, 8'h01);
    checks++;
    if (r !== 8'h02 || done !== 1'b1 || {fz, fc, fn, fv} !== 4'b0000) begin
      errors++; $display("FAIL midmul_then_add r=%h done=%b zcnv=%b want r=02 done=1 zcnv=0000", r, done, {fz, fc, fn, fv});
    end
  endtask

  task automatic test_back_to_back;
    int lat, busy_n;
    @(negedge clk);
    issue(ADD, 8'h03, 8'h04);
    checks++;
    if (r !== 8'h07 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_add r=%h done=%b want r=07 done=1", r, done);
    end
    issue(SUB, 8'h09, 8'h04);
    checks++;
    if (r !== 8'h05 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_sub r=%h done=%b want r=05 done=1", r, done);
    end
    issue(XOR_, 8'hAA, 8'h0F);
    checks++;
    if (r !== 8'hA5 || done !== 1'b1 || {fz, fc, fn, fv} !== 4'b0010) begin
      errors++; $display("FAIL b2b_xor r=%h done=%b zcnv=%b want r=a5 done=1 zcnv=0010", r, done, {fz, fc, fn, fv});
    end
    issue(MUL, 8'h03, 8'h05);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_mul_accept busy=%b done=%b want busy=1 done=0", busy, done);
    end
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 8 || r !== 8'h0F || {fz, fc, fn, fv} !== 4'b0000) begin
      errors++; $display("FAIL b2b_mul lat=%0d r=%h zcnv=%b want lat=8 r=0f zcnv=0000", lat, r, {fz, fc, fn, fv});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_start_while_busy();
    test_reset_mid_mul();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
